mem_access_unit: RTL and testbench
==================================

MEM_ACCESS_UNIT -- requirements
Module: mem_access_unit

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 8, meaning word-index bits (depth = 2**ADDR_WIDTH words).
REQ-002 SHALL have parameter DATA_WIDTH, default 32, meaning word width; only 32 is supported.
REQ-003 SHALL have parameter LATENCY, default 2, meaning acceptance-to-response cycles for memory ops; legal values are >=1.
REQ-004 SHALL have port clk  in  1  single clock; all state updates on rising edge.
REQ-005 SHALL have port reset  in  1  asynchronous, active-low reset.
REQ-006 SHALL have port req_valid  in  1  request present.
REQ-007 SHALL have port req_ready  out  1  request accepted this cycle when high with req_valid.
REQ-008 SHALL have ports mem_read, mem_write, mem_unsigned  in  1 each  load, store, and zero-extend select.
REQ-009 SHALL have port mem_size  in  2  00 byte, 01 halfword, 10 word; 11 is treated as word.
REQ-010 SHALL have port alu_result_in  in  32  byte address, or pass-through value for non-memory ops.
REQ-011 SHALL have port write_data_in  in  32  store data, taken from the low bits.
REQ-012 SHALL have ports write_register_in (in, 5), reg_write_in (in, 1), mem_to_reg_in (in, 1)  WB control.
REQ-013 SHALL have port resp_valid  out  1  response outputs valid.
REQ-014 SHALL have ports read_data_out (out, 32), alu_result_out (out, 32), write_register_out (out, 5), reg_write_out (out, 1), mem_to_reg_out (out, 1)  registered response.
REQ-015 SHALL have port misaligned  out  1  response is an aborted misaligned access.
REQ-016 SHALL have port stall  out  1  equals req_valid AND NOT req_ready.

Function
REQ-017 SHALL implement an FSM with states IDLE, BUSY and RESP.
REQ-018 SHALL drive req_ready=1 in IDLE and RESP, and req_ready=0 in BUSY.
REQ-019 SHALL, on acceptance, capture all request inputs into internal registers.
REQ-020 SHALL classify an access as misaligned when (half and addr[0]=1) or (word and addr[1:0]!=00); this applies only when mem_read or mem_write is set.
REQ-021 SHALL, for non-memory or misaligned requests, go to RESP on the next edge; response latency is 1.
REQ-022 SHALL, for aligned memory requests, go to RESP after LATENCY edges; with LATENCY=1 it goes directly to RESP, otherwise through BUSY with a down-counter loaded with LATENCY-2.
REQ-023 SHALL, in RESP, assert resp_valid for exactly one cycle per request; it then goes to IDLE, or accepts a new request in the same cycle (back-to-back).
REQ-024 SHALL hold response outputs stable until the next response; resp_valid alone marks validity.
REQ-025 SHALL form the word index as alu_result[ADDR_WIDTH+1:2]; upper address bits are ignored, so addresses wrap modulo depth.
REQ-026 SHALL, on store, write only byte lanes selected little-endian by addr[1:0]: byte writes lane addr[1:0]; halfword writes lanes {addr[1],0} and {addr[1],1}; word writes all lanes.
REQ-027 SHALL commit store data to the array on the edge entering RESP; a misaligned store SHALL NOT modify memory.
REQ-028 SHALL, on load, extract the addressed byte/halfword and sign-extend it (mem_unsigned=0) or zero-extend it (mem_unsigned=1) to 32 bits; word loads pass through unchanged.
REQ-029 SHALL read the array on the edge entering RESP, so an earlier store is always visible to a later load.
REQ-030 SHALL treat mem_read and mem_write both set as a store, with read_data_out=0.
REQ-031 SHALL output read_data_out=0 for non-load responses and for misaligned responses.
REQ-032 SHALL output alu_result_out, write_register_out and mem_to_reg_out as the captured inputs.
REQ-033 SHALL output reg_write_out as the captured reg_write_in, forced to 0 on misaligned responses.
REQ-034 SHALL set misaligned=1 only on the response of a misaligned request, and 0 otherwise.

Reset
REQ-035 SHALL, while reset=0, force FSM to IDLE, the counter to 0, and resp_valid, misaligned, reg_write_out and mem_to_reg_out to 0, with read_data_out, alu_result_out and write_register_out all zero.
REQ-036 SHALL, on reset asserted mid-operation, abandon the pending access; an uncommitted store SHALL NOT modify memory.
REQ-037 SHALL NOT clear the memory array on reset; the array is zero-initialised at simulation start.

Verification
REQ-038 SHALL cover: LATENCY=2, SW 0xDEADBEEF @0x10 then LW @0x10 -> each resp_valid 2 cycles after acceptance, stall=1 during BUSY, read 0xDEADBEEF.
REQ-039 SHALL cover: SB 0x80 @0x21, then LB @0x21 and LBU @0x21 -> 0xFFFFFF80 and 0x00000080; LW @0x20 -> 0x00008000.
REQ-040 SHALL cover: LH @0x13 and SW @0x22 -> each gives misaligned=1, reg_write_out=0, read_data_out=0, a 1-cycle response, and memory unchanged.
REQ-041 SHALL cover: ADDR_WIDTH=8, SW 0x1234 @0x400 then LW @0x0 -> 0x1234 (wrap).
REQ-042 SHALL cover: non-memory request alu_result_in=0x55, write_register_in=7, reg_write_in=1, accepted in RESP of a previous load -> resp_valid on the next cycle with alu_result_out=0x55, write_register_out=7, reg_write_out=1, read_data_out=0.
REQ-043 SHALL cover: reset=0 during BUSY of SW 0xAA @0x30, then LW @0x30 -> outputs zero during reset, then read returns prior content 0.

Source files
------------

// File: rtl/mem_access_unit.sv
// Data-memory access stage: handshaked load/store unit with a byte-lane
// addressable word array, fixed access latency and misaligned-access abort.
module mem_access_unit #(
    parameter int ADDR_WIDTH = 8,
    parameter int DATA_WIDTH = 32,
    parameter int LATENCY    = 2
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  mem_read,
    input  logic                  mem_write,
    input  logic                  mem_unsigned,
    input  logic [1:0]            mem_size,
    input  logic [31:0]           alu_result_in,
    input  logic [DATA_WIDTH-1:0] write_data_in,
    input  logic [4:0]            write_register_in,
    input  logic                  reg_write_in,
    input  logic                  mem_to_reg_in,
    output logic                  resp_valid,
    output logic [DATA_WIDTH-1:0] read_data_out,
    output logic [31:0]           alu_result_out,
    output logic [4:0]            write_register_out,
    output logic                  reg_write_out,
    output logic                  mem_to_reg_out,
    output logic                  misaligned,
    output logic                  stall
);
    localparam int DEPTH = 2 ** ADDR_WIDTH;
    localparam int CW    = (LATENCY > 2) ? $clog2(LATENCY) : 1;

    typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;

    state_t          state, state_next;
    logic [CW-1:0]   cnt, cnt_next;
    logic [31:0]     mem [DEPTH] = '{default: '0};

    logic [31:0]     q_addr, q_wdata;
    logic [1:0]      q_size;
    logic            q_unsigned, q_read, q_write, q_regw, q_m2r;
    logic [4:0]      q_wreg;

    logic [31:0]     cur_addr, cur_wdata;
    logic [1:0]      cur_size;
    logic            cur_unsigned, cur_read, cur_write, cur_regw, cur_m2r;
    logic [4:0]      cur_wreg;
    logic            cur_mis, accept, enter_resp, we;
    logic [ADDR_WIDTH-1:0] cur_idx;
    logic [31:0]     rd_word, shifted, ext, load_data, wd;
    logic [3:0]      be;

    assign accept = req_valid && req_ready;

    // The op that lands in RESP comes straight from the inputs when it is
    // accepted on that same edge, otherwise from the captured copy.
    always_comb begin
        cur_addr     = accept ? alu_result_in     : q_addr;
        cur_wdata    = accept ? write_data_in     : q_wdata;
        cur_size     = accept ? mem_size          : q_size;
        cur_unsigned = accept ? mem_unsigned      : q_unsigned;
        cur_read     = accept ? mem_read          : q_read;
        cur_write    = accept ? mem_write         : q_write;
        cur_wreg     = accept ? write_register_in : q_wreg;
        cur_regw     = accept ? reg_write_in      : q_regw;
        cur_m2r      = accept ? mem_to_reg_in     : q_m2r;
        cur_mis      = (cur_read || cur_write) &&
                       ((cur_size == 2'b01 && cur_addr[0]) ||
                        (cur_size[1] && cur_addr[1:0] != 2'b00));
        cur_idx      = cur_addr[ADDR_WIDTH+1:2];
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= state_next;
            cnt   <= cnt_next;
        end
    end

    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        case (state)
            BUSY: begin
                if (cnt == '0) state_next = RESP;
                else           cnt_next   = cnt - CW'(1);
            end
            default: begin
                if (accept) begin
                    if (!(cur_read || cur_write) || cur_mis || LATENCY == 1) begin
                        state_next = RESP;
                    end else begin
                        state_next = BUSY;
                        cnt_next   = CW'(LATENCY - 2);
                    end
                end else begin
                    state_next = IDLE;
                end
            end
        endcase
    end

    always_comb begin
        req_ready  = (state != BUSY);
        resp_valid = (state == RESP);
        stall      = req_valid && !req_ready;
    end

    assign enter_resp = (state_next == RESP);
    assign we         = enter_resp && cur_write && !cur_mis;

    always_comb begin
        rd_word = mem[cur_idx];
        shifted = rd_word >> {cur_addr[1:0], 3'b000};
        case (cur_size)
            2'b00: ext = cur_unsigned ? {24'h0, shifted[7:0]}
                                      : {{24{shifted[7]}}, shifted[7:0]};
            2'b01: ext = cur_unsigned ? {16'h0, shifted[15:0]}
                                      : {{16{shifted[15]}}, shifted[15:0]};
            default: ext = rd_word;
        endcase
        load_data = (cur_read && !cur_write && !cur_mis) ? ext : '0;
        case (cur_size)
            2'b00:   begin be = 4'b0001 << cur_addr[1:0];         wd = {4{cur_wdata[7:0]}};  end
            2'b01:   begin be = 4'b0011 << {cur_addr[1], 1'b0};   wd = {2{cur_wdata[15:0]}}; end
            default: begin be = 4'b1111;                          wd = cur_wdata;            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (we && reset) begin
            for (int unsigned i = 0; i < 4; i++) begin
                if (be[i]) mem[cur_idx][8*i +: 8] <= wd[8*i +: 8];
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            q_addr <= '0; q_wdata <= '0; q_size <= '0; q_unsigned <= 1'b0;
            q_read <= 1'b0; q_write <= 1'b0; q_wreg <= '0; q_regw <= 1'b0; q_m2r <= 1'b0;
            read_data_out      <= '0;
            alu_result_out     <= '0;
            write_register_out <= '0;
            reg_write_out      <= 1'b0;
            mem_to_reg_out     <= 1'b0;
            misaligned         <= 1'b0;
        end else begin
            if (accept) begin
                q_addr <= alu_result_in; q_wdata <= write_data_in; q_size <= mem_size;
                q_unsigned <= mem_unsigned; q_read <= mem_read; q_write <= mem_write;
                q_wreg <= write_register_in; q_regw <= reg_write_in; q_m2r <= mem_to_reg_in;
            end
            if (enter_resp) begin
                read_data_out      <= load_data;
                alu_result_out     <= cur_addr;
                write_register_out <= cur_wreg;
                reg_write_out      <= cur_regw && !cur_mis;
                mem_to_reg_out     <= cur_m2r;
                misaligned         <= cur_mis;
            end
        end
    end
endmodule

// File: tb/tb_mem_access_unit.sv
// Directed self-checking bench for mem_access_unit (LATENCY=2, ADDR_WIDTH=8).
module tb_mem_access_unit;
    logic        clk = 1'b0;
    logic        reset;
    logic        req_valid, req_ready, mem_read, mem_write, mem_unsigned;
    logic [1:0]  mem_size;
    logic [31:0] alu_result_in, write_data_in;
    logic [4:0]  write_register_in;
    logic        reg_write_in, mem_to_reg_in;
    logic        resp_valid;
    logic [31:0] read_data_out, alu_result_out;
    logic [4:0]  write_register_out;
    logic        reg_write_out, mem_to_reg_out, misaligned, stall;

    int total = 0;
    int bad   = 0;

    mem_access_unit #(.ADDR_WIDTH(8), .DATA_WIDTH(32), .LATENCY(2)) dut (
        .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
        .mem_read(mem_read), .mem_write(mem_write), .mem_unsigned(mem_unsigned),
        .mem_size(mem_size), .alu_result_in(alu_result_in), .write_data_in(write_data_in),
        .write_register_in(write_register_in), .reg_write_in(reg_write_in),
        .mem_to_reg_in(mem_to_reg_in), .resp_valid(resp_valid),
        .read_data_out(read_data_out), .alu_result_out(alu_result_out),
        .write_register_out(write_register_out), .reg_write_out(reg_write_out),
        .mem_to_reg_out(mem_to_reg_out), .misaligned(misaligned), .stall(stall)
    );

    always #5 clk = ~clk;

    task automatic idle_inputs();
        req_valid = 0; mem_read = 0; mem_write = 0; mem_unsigned = 0; mem_size = 2'b10;
        alu_result_in = '0; write_data_in = '0; write_register_in = '0;
        reg_write_in = 0; mem_to_reg_in = 0;
    endtask

    task automatic set_req(input logic rd, input logic wr, input logic uns, input logic [1:0] sz,
                           input logic [31:0] addr, input logic [31:0] wdata,
                           input logic [4:0] wreg, input logic rw, input logic m2r);
        req_valid = 1; mem_read = rd; mem_write = wr; mem_unsigned = uns; mem_size = sz;
        alu_result_in = addr; write_data_in = wdata; write_register_in = wreg;
        reg_write_in = rw; mem_to_reg_in = m2r;
    endtask

    // Called at a negedge; returns cycles from acceptance edge to resp_valid.
    task automatic send(input logic rd, input logic wr, input logic uns, input logic [1:0] sz,
                        input logic [31:0] addr, input logic [31:0] wdata,
                        input logic [4:0] wreg, input logic rw, input logic m2r, output int lat);
        set_req(rd, wr, uns, sz, addr, wdata, wreg, rw, m2r);
        @(posedge clk); @(negedge clk);
        idle_inputs();
        lat = 1;
        while (!resp_valid && lat < 20) begin @(negedge clk); lat++; end
    endtask

    task automatic test_reset();
        total++; if (resp_valid !== 1'b0) begin bad++; $display("FAIL rst_resp_valid got=%b want=0", resp_valid); end
        total++; if (req_ready !== 1'b1) begin bad++; $display("FAIL rst_req_ready got=%b want=1", req_ready); end
        total++; if ({read_data_out, alu_result_out, write_register_out, reg_write_out, mem_to_reg_out, misaligned} !== '0)
            begin bad++; $display("FAIL rst_outputs got=%h/%h/%h/%b%b%b want=0", read_data_out, alu_result_out, write_register_out, reg_write_out, mem_to_reg_out, misaligned); end
        total++; if (stall !== 1'b0) begin bad++; $display("FAIL rst_stall got=%b want=0", stall); end
    endtask

    task automatic test_latency();
        set_req(0, 1, 0, 2'b10, 32'h10, 32'hDEADBEEF, 5'd0, 0, 0);
        @(posedge clk); @(negedge clk);
        total++; if (req_ready !== 1'b0) begin bad++; $display("FAIL busy_ready got=%b want=0", req_ready); end
        total++; if (stall !== 1'b1) begin bad++; $display("FAIL busy_stall got=%b want=1", stall); end
        total++; if (resp_valid !== 1'b0) begin bad++; $display("FAIL busy_resp got=%b want=0", resp_valid); end
        set_req(1, 0, 0, 2'b10, 32'h10, 32'h0, 5'd3, 1, 1);
        @(posedge clk); @(negedge clk);
        total++; if (resp_valid !== 1'b1) begin bad++; $display("FAIL sw_resp got=%b want=1", resp_valid); end
        total++; if (read_data_out !== 32'h0) begin bad++; $display("FAIL sw_rdata got=%h want=0", read_data_out); end
        @(posedge clk); @(negedge clk);
        idle_inputs();
        total++; if (resp_valid !== 1'b0) begin bad++; $display("FAIL lw_busy_resp got=%b want=0", resp_valid); end
        @(posedge clk); @(negedge clk);
        total++; if (resp_valid !== 1'b1) begin bad++; $display("FAIL lw_resp got=%b want=1", resp_valid); end
        total++; if (read_data_out !== 32'hDEADBEEF) begin bad++; $display("FAIL lw_rdata got=%h want=deadbeef", read_data_out); end
        total++; if (write_register_out !== 5'd3 || mem_to_reg_out !== 1'b1 || reg_write_out !== 1'b1)
            begin bad++; $display("FAIL lw_wb got=%0d/%b/%b want=3/1/1", write_register_out, mem_to_reg_out, reg_write_out); end
    endtask

    task automatic test_subword();
        int lat;
        send(0, 1, 0, 2'b00, 32'h21, 32'h80, 5'd0, 0, 0, lat);
        total++; if (lat !== 2) begin bad++; $display("FAIL sb_lat got=%0d want=2", lat); end
        send(1, 0, 0, 2'b00, 32'h21, 32'h0, 5'd1, 1, 1, lat);
        total++; if (read_data_out !== 32'hFFFFFF80) begin bad++; $display("FAIL lb got=%h want=ffffff80", read_data_out); end
        send(1, 0, 1, 2'b00, 32'h21, 32'h0, 5'd1, 1, 1, lat);
        total++; if (read_data_out !== 32'h00000080) begin bad++; $display("FAIL lbu got=%h want=00000080", read_data_out); end
        send(1, 0, 0, 2'b10, 32'h20, 32'h0, 5'd1, 1, 1, lat);
        total++; if (read_data_out !== 32'h00008000) begin bad++; $display("FAIL lw_20 got=%h want=00008000", read_data_out); end
        send(0, 1, 0, 2'b01, 32'h42, 32'h1234BEEF, 5'd0, 0, 0, lat);
        send(1, 0, 0, 2'b01, 32'h42, 32'h0, 5'd1, 1, 1, lat);
        total++; if (read_data_out !== 32'hFFFFBEEF) begin bad++; $display("FAIL lh got=%h want=ffffbeef", read_data_out); end
        send(1, 0, 1, 2'b01, 32'h42, 32'h0, 5'd1, 1, 1, lat);
        total++; if (read_data_out !== 32'h0000BEEF) begin bad++; $display("FAIL lhu got=%h want=0000beef", read_data_out); end
        send(1, 0, 0, 2'b11, 32'h40, 32'h0, 5'd1, 1, 1, lat);
        total++; if (read_data_out !== 32'hBEEF0000) begin bad++; $display("FAIL lw_40 got=%h want=beef0000", read_data_out); end
        send(1, 1, 0, 2'b10, 32'h50, 32'h77, 5'd1, 1, 0, lat);
        total++; if (read_data_out !== 32'h0) begin bad++; $display("FAIL rw_store_rdata got=%h want=0", read_data_out); end
        send(1, 0, 0, 2'b10, 32'h50, 32'h0, 5'd1, 1, 1, lat);
        total++; if (read_data_out !== 32'h77) begin bad++; $display("FAIL rw_store_lw got=%h want=77", read_data_out); end
    endtask

    task automatic test_misaligned();
        int lat;
        send(1, 0, 0, 2'b01, 32'h13, 32'h0, 5'd4, 1, 1, lat);
        total++; if (lat !== 1) begin bad++; $display("FAIL lh13_lat got=%0d want=1", lat); end
        total++; if ({misaligned, reg_write_out} !== 2'b10) begin bad++; $display("FAIL lh13_flags got=%b%b want=10", misaligned, reg_write_out); end
        total++; if (read_data_out !== 32'h0) begin bad++; $display("FAIL lh13_rdata got=%h want=0", read_data_out); end
        send(0, 1, 0, 2'b10, 32'h22, 32'h11111111, 5'd0, 1, 0, lat);
        total++; if (lat !== 1 || misaligned !== 1'b1 || reg_write_out !== 1'b0)
            begin bad++; $display("FAIL sw22 got=lat%0d/%b/%b want=lat1/1/0", lat, misaligned, reg_write_out); end
        send(1, 0, 0, 2'b10, 32'h20, 32'h0, 5'd1, 1, 1, lat);
        total++; if (read_data_out !== 32'h00008000) begin bad++; $display("FAIL sw22_mem got=%h want=00008000", read_data_out); end
        total++; if (misaligned !== 1'b0) begin bad++; $display("FAIL mis_clear got=%b want=0", misaligned); end
        send(1, 0, 0, 2'b10, 32'h10, 32'h0, 5'd1, 1, 1, lat);
        total++; if (read_data_out !== 32'hDEADBEEF) begin bad++; $display("FAIL lh13_mem got=%h want=deadbeef", read_data_out); end
    endtask

    task automatic test_wrap();
        int lat;
        send(0, 1, 0, 2'b10, 32'h400, 32'h1234, 5'd0, 0, 0, lat);
        send(1, 0, 0, 2'b10, 32'h0, 32'h0, 5'd1, 1, 1, lat);
        total++; if (read_data_out !== 32'h1234) begin bad++; $display("FAIL wrap got=%h want=00001234", read_data_out); end
    endtask

    task automatic test_back_to_back();
        int lat;
        send(1, 0, 0, 2'b10, 32'h10, 32'h0, 5'd2, 1, 1, lat);
        total++; if (read_data_out !== 32'hDEADBEEF) begin bad++; $display("FAIL b2b_lw got=%h want=deadbeef", read_data_out); end
        send(0, 0, 0, 2'b10, 32'h55, 32'h0, 5'd7, 1, 0, lat);
        total++; if (lat !== 1) begin bad++; $display("FAIL b2b_lat got=%0d want=1", lat); end
        total++; if (alu_result_out !== 32'h55 || write_register_out !== 5'd7 || reg_write_out !== 1'b1 || mem_to_reg_out !== 1'b0)
            begin bad++; $display("FAIL b2b_fields got=%h/%0d/%b/%b want=55/7/1/0", alu_result_out, write_register_out, reg_write_out, mem_to_reg_out); end
        total++; if (read_data_out !== 32'h0) begin bad++; $display("FAIL b2b_rdata got=%h want=0", read_data_out); end
        @(negedge clk);
        total++; if (resp_valid !== 1'b0) begin bad++; $display("FAIL resp_pulse got=%b want=0", resp_valid); end
        total++; if (alu_result_out !== 32'h55) begin bad++; $display("FAIL resp_hold got=%h want=55", alu_result_out); end
    endtask

    task automatic test_reset_mid();
        int lat;
        set_req(0, 1, 0, 2'b10, 32'h30, 32'hAA, 5'd0, 0, 0);
        @(posedge clk); @(negedge clk);
        idle_inputs();
        reset = 0;
        #1;
        total++; if (resp_valid !== 1'b0 || req_ready !== 1'b1) begin bad++; $display("FAIL mid_rst_fsm got=%b/%b want=0/1", resp_valid, req_ready); end
        total++; if ({read_data_out, alu_result_out, write_register_out, reg_write_out, mem_to_reg_out, misaligned} !== '0)
            begin bad++; $display("FAIL mid_rst_outputs got=%h/%h want=0/0", read_data_out, alu_result_out); end
        repeat (2) @(negedge clk);
        reset = 1;
        @(negedge clk);
        send(1, 0, 0, 2'b10, 32'h30, 32'h0, 5'd1, 1, 1, lat);
        total++; if (lat !== 2) begin bad++; $display("FAIL mid_rst_lat got=%0d want=2", lat); end
        total++; if (read_data_out !== 32'h0) begin bad++; $display("FAIL mid_rst_mem got=%h want=0", read_data_out); end
    endtask

    initial begin
        idle_inputs();
        reset = 0;
        repeat (2) @(negedge clk);
        test_reset();
        reset = 1;
        @(negedge clk);
        test_latency();
        @(negedge clk);
        test_subword();
        test_misaligned();
        test_wrap();
        test_back_to_back();
        @(negedge clk);
        test_reset_mid();
        repeat (2) @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
